// File: rtl/rob_multiport_pkg.sv
// Shared definitions for the multi-port reorder buffer: default sizing, tag type
// and the per-entry payload record.
package rob_pkg;
    localparam int DEPTH_DEF    = 64;
    localparam int TAG_W_DEF    = $clog2(DEPTH_DEF);
    localparam int DISP_W_DEF   = 2;
    localparam int COMMIT_W_DEF = 2;
    localparam int NUM_FIN_DEF  = 5;
    localparam int PC_W         = 32;
    localparam int REG_W        = 5;
    localparam int BHR_W        = 10;

    typedef logic [TAG_W_DEF-1:0] tag_t;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [REG_W-1:0] dst;
        logic             dstvalid;
        logic             store;
        logic             isbranch;
        logic [BHR_W-1:0] bhr;
    } entry_t;
endpackage

// File: rtl/rob_multiport_if.sv
// Dispatch / finish / flush / commit bundle of the reorder buffer.
// ROB_EXC_EN adds the exception finish flag and exception commit outputs.
interface rob_multiport_if
    import rob_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int TAG_W    = $clog2(DEPTH),
    parameter int DISP_W   = DISP_W_DEF,
    parameter int COMMIT_W = COMMIT_W_DEF,
    parameter int NUM_FIN  = NUM_FIN_DEF
) ();
    logic [DISP_W-1:0]                  disp_valid;
    logic                               disp_ready;
    logic [DISP_W-1:0][TAG_W-1:0]       disp_tag;
    logic [DISP_W-1:0][PC_W-1:0]        disp_pc;
    logic [DISP_W-1:0]                  disp_isbranch;
    logic [DISP_W-1:0]                  disp_store;
    logic [DISP_W-1:0]                  disp_dstvalid;
    logic [DISP_W-1:0][REG_W-1:0]       disp_dst;
    logic [DISP_W-1:0][BHR_W-1:0]       disp_bhr;
    logic [NUM_FIN-1:0]                 fin_valid;
    logic [NUM_FIN-1:0][TAG_W-1:0]      fin_tag;
    logic                               finbr_valid;
    logic [TAG_W-1:0]                   finbr_tag;
    logic                               finbr_brcond;
    logic [PC_W-1:0]                    finbr_jmpaddr;
    logic                               flush_valid;
    logic [TAG_W-1:0]                   flush_tag;
    logic [COMMIT_W-1:0]                com_valid;
    logic [COMMIT_W-1:0][TAG_W-1:0]     com_tag;
    logic [COMMIT_W-1:0]                com_arfwe;
    logic [COMMIT_W-1:0][REG_W-1:0]     com_dst;
    logic                               com_store;
    logic                               combr_valid;
    logic [PC_W-1:0]                    combr_pc;
    logic [BHR_W-1:0]                   combr_bhr;
    logic                               combr_brcond;
    logic [PC_W-1:0]                    combr_jmpaddr;
    logic [TAG_W:0]                     count;
`ifdef ROB_EXC_EN
    logic [NUM_FIN-1:0]                 fin_exc;
    logic                               exc_commit;
    logic [PC_W-1:0]                    exc_pc;
`endif

    modport master (
        output disp_valid, disp_pc, disp_isbranch, disp_store, disp_dstvalid, disp_dst, disp_bhr,
        output fin_valid, fin_tag, finbr_valid, finbr_tag, finbr_brcond, finbr_jmpaddr,
        output flush_valid, flush_tag,
`ifdef ROB_EXC_EN
        output fin_exc,
        input  exc_commit, exc_pc,
`endif
        input  disp_ready, disp_tag, com_valid, com_tag, com_arfwe, com_dst, com_store,
        input  combr_valid, combr_pc, combr_bhr, combr_brcond, combr_jmpaddr, count
    );

    modport slave (
        input  disp_valid, disp_pc, disp_isbranch, disp_store, disp_dstvalid, disp_dst, disp_bhr,
        input  fin_valid, fin_tag, finbr_valid, finbr_tag, finbr_brcond, finbr_jmpaddr,
        input  flush_valid, flush_tag,
`ifdef ROB_EXC_EN
        input  fin_exc,
        output exc_commit, exc_pc,
`endif
        output disp_ready, disp_tag, com_valid, com_tag, com_arfwe, com_dst, com_store,
        output combr_valid, combr_pc, combr_bhr, combr_brcond, combr_jmpaddr, count
    );
endinterface

// File: rtl/rob_multiport_commit_sel.sv
// Picks up to COMMIT_W in-order retirements starting at head; a branch, store or
// exception entry ends the group, and an exception entry may only retire in slot 0.
module rob_commit_sel #(
    parameter int DEPTH    = 64,
    parameter int TAG_W    = $clog2(DEPTH),
    parameter int COMMIT_W = 2
) (
    input  logic [TAG_W-1:0]    i_head,
    input  logic [TAG_W:0]      i_count,
    input  logic                i_block,
    input  logic [DEPTH-1:0]    i_finish,
    input  logic [DEPTH-1:0]    i_isbranch,
    input  logic [DEPTH-1:0]    i_store,
    input  logic [DEPTH-1:0]    i_solo,
    output logic [COMMIT_W-1:0] o_valid,
    output logic [TAG_W:0]      o_ncom
);
    logic             w_stop;
    logic [TAG_W-1:0] w_idx;

    always_comb begin
        o_valid = '0;
        o_ncom  = '0;
        w_stop  = i_block;
        w_idx   = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            w_idx = i_head + TAG_W'(k);
            if (!w_stop && ((TAG_W+1)'(k) < i_count) && i_finish[w_idx]
                && !((k > 0) && i_solo[w_idx])) begin
                o_valid[k] = 1'b1;
                o_ncom     = o_ncom + (TAG_W+1)'(1);
                if (i_isbranch[w_idx] || i_store[w_idx] || i_solo[w_idx]) begin
                    w_stop = 1'b1;
                end
            end else begin
                w_stop = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rob_multiport.sv
// Circular in-order reorder buffer with multi-slot dispatch/commit, finish ports
// and selective flush. Define ROB_EXC_EN for precise-exception commit/flush.
module rob_multiport
    import rob_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int TAG_W    = $clog2(DEPTH),
    parameter int DISP_W   = DISP_W_DEF,
    parameter int COMMIT_W = COMMIT_W_DEF,
    parameter int NUM_FIN  = NUM_FIN_DEF
) (
    input  logic           clk,
    input  logic           reset,
    rob_multiport_if.slave bus
);
    logic [TAG_W-1:0]  r_head, r_tail;
    logic [TAG_W:0]    r_count;
    logic [DEPTH-1:0]  r_finish, r_brcond;
    entry_t            r_ent     [DEPTH];
    logic [PC_W-1:0]   r_jmpaddr [DEPTH];

    logic                           w_fire, w_clash;
    logic [TAG_W:0]                 w_ndisp, w_ncom;
    logic [DISP_W-1:0][TAG_W-1:0]   w_dtag;
    logic [COMMIT_W-1:0][TAG_W-1:0] w_ctag;
    entry_t                         w_cent [COMMIT_W];
    logic [COMMIT_W-1:0]            w_cv;
    logic [DEPTH-1:0]               w_isbr, w_st, w_solo;
    logic [TAG_W-1:0]               w_fdist;

    assign bus.disp_ready = (r_count <= (TAG_W+1)'(DEPTH - DISP_W));
    assign w_fire         = bus.disp_ready && !bus.flush_valid;
    assign bus.count      = r_count;
    assign w_fdist        = bus.flush_tag - r_head;

    genvar gi;
    generate
        for (gi = 0; gi < DISP_W; gi++) begin : g_disp
            assign w_dtag[gi]       = r_tail + TAG_W'(gi);
            assign bus.disp_tag[gi] = w_dtag[gi];
        end
        for (gi = 0; gi < DEPTH; gi++) begin : g_vec
            assign w_isbr[gi] = r_ent[gi].isbranch;
            assign w_st[gi]   = r_ent[gi].store;
        end
        for (gi = 0; gi < COMMIT_W; gi++) begin : g_com
            assign w_ctag[gi]        = r_head + TAG_W'(gi);
            assign w_cent[gi]        = r_ent[w_ctag[gi]];
            assign bus.com_tag[gi]   = w_cv[gi] ? w_ctag[gi] : '0;
            assign bus.com_arfwe[gi] = w_cv[gi] & w_cent[gi].dstvalid & ~w_solo[w_ctag[gi]];
            assign bus.com_dst[gi]   = w_cv[gi] ? w_cent[gi].dst : '0;
        end
    endgenerate
    assign bus.com_valid = w_cv;

    rob_commit_sel #(.DEPTH(DEPTH), .TAG_W(TAG_W), .COMMIT_W(COMMIT_W)) u_sel (
        .i_head(r_head), .i_count(r_count), .i_block(bus.flush_valid),
        .i_finish(r_finish), .i_isbranch(w_isbr), .i_store(w_st), .i_solo(w_solo),
        .o_valid(w_cv), .o_ncom(w_ncom)
    );

`ifdef ROB_EXC_EN
    logic [DEPTH-1:0] r_exc;
    logic             w_exc_commit;
    assign w_solo         = r_exc;
    assign w_exc_commit   = w_cv[0] & r_exc[r_head];
    assign bus.exc_commit = w_exc_commit;
    assign bus.exc_pc     = w_exc_commit ? w_cent[0].pc : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exc <= '0;
        end else begin
            for (int i = 0; i < DISP_W; i++)
                if (w_fire && bus.disp_valid[i]) r_exc[w_dtag[i]] <= 1'b0;
            for (int f = 0; f < NUM_FIN; f++)
                if (bus.fin_valid[f] && bus.fin_exc[f]) r_exc[bus.fin_tag[f]] <= 1'b1;
        end
    end
`else
    assign w_solo = '0;
`endif

    always_comb begin
        w_ndisp = '0;
        w_clash = 1'b0;
        for (int i = 0; i < DISP_W; i++) begin
            if (w_fire && bus.disp_valid[i]) begin
                w_ndisp = w_ndisp + (TAG_W+1)'(1);
                for (int f = 0; f < NUM_FIN; f++)
                    if (bus.fin_valid[f] && bus.fin_tag[f] == w_dtag[i]) w_clash = 1'b1;
                if (bus.finbr_valid && bus.finbr_tag == w_dtag[i]) w_clash = 1'b1;
            end
        end
    end

    // Only one branch/store can be in a commit group, so a priority mux suffices.
    always_comb begin
        bus.com_store     = 1'b0;
        bus.combr_valid   = 1'b0;
        bus.combr_pc      = '0;
        bus.combr_bhr     = '0;
        bus.combr_brcond  = 1'b0;
        bus.combr_jmpaddr = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (w_cv[k] && w_cent[k].store) bus.com_store = 1'b1;
            if (w_cv[k] && w_cent[k].isbranch) begin
                bus.combr_valid   = 1'b1;
                bus.combr_pc      = w_cent[k].pc;
                bus.combr_bhr     = w_cent[k].bhr;
                bus.combr_brcond  = r_brcond[w_ctag[k]];
                bus.combr_jmpaddr = r_jmpaddr[w_ctag[k]];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush_valid) begin
            r_tail  <= bus.flush_tag + TAG_W'(1);
            r_count <= {1'b0, w_fdist} + (TAG_W+1)'(1);
`ifdef ROB_EXC_EN
        end else if (w_exc_commit) begin
            r_head  <= r_head + TAG_W'(1);
            r_tail  <= r_head + TAG_W'(1);
            r_count <= '0;
`endif
        end else begin
            r_head  <= r_head + w_ncom[TAG_W-1:0];
            r_tail  <= r_tail + w_ndisp[TAG_W-1:0];
            r_count <= r_count + w_ndisp - w_ncom;
        end
    end

    // Set after clear: a finish strobe overrides a dispatch clear on the same tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_finish <= '0;
            r_brcond <= '0;
        end else begin
            for (int i = 0; i < DISP_W; i++)
                if (w_fire && bus.disp_valid[i]) r_finish[w_dtag[i]] <= 1'b0;
            for (int f = 0; f < NUM_FIN; f++)
                if (bus.fin_valid[f]) r_finish[bus.fin_tag[f]] <= 1'b1;
            if (bus.finbr_valid) begin
                r_finish[bus.finbr_tag] <= 1'b1;
                r_brcond[bus.finbr_tag] <= bus.finbr_brcond;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DISP_W; i++) begin
            if (w_fire && bus.disp_valid[i]) begin
                r_ent[w_dtag[i]] <= '{pc: bus.disp_pc[i], dst: bus.disp_dst[i],
                                      dstvalid: bus.disp_dstvalid[i], store: bus.disp_store[i],
                                      isbranch: bus.disp_isbranch[i], bhr: bus.disp_bhr[i]};
            end
        end
        if (bus.finbr_valid) r_jmpaddr[bus.finbr_tag] <= bus.finbr_jmpaddr;
    end

    a_no_clash: assert property (@(posedge clk) disable iff (reset) !w_clash);
endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport: expected commits go into a scoreboard queue
// that a negedge monitor drains whenever the buffer presents commit slots.
module tb_rob_multiport;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   tb_tail = 0;

    typedef struct {
        int          tag;
        bit          arfwe;
        int          dst;
        bit          st;
        bit          br;
        bit          brcond;
        logic [31:0] jmp;
        logic [31:0] pc;
        logic [9:0]  bhr;
    } exp_t;
    exp_t sbq[$];

    rob_multiport_if bus ();
    rob_multiport dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.disp_valid = '0; bus.disp_pc = '0; bus.disp_isbranch = '0; bus.disp_store = '0;
        bus.disp_dstvalid = '0; bus.disp_dst = '0; bus.disp_bhr = '0;
        bus.fin_valid = '0; bus.fin_tag = '0; bus.finbr_valid = 1'b0; bus.finbr_tag = '0;
        bus.finbr_brcond = 1'b0; bus.finbr_jmpaddr = '0; bus.flush_valid = 1'b0; bus.flush_tag = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
        bus.disp_valid = '0; bus.fin_valid = '0; bus.finbr_valid = 1'b0; bus.flush_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step(); step();
        reset = 1'b0;
        tb_tail = 0;
    endtask

    task automatic set_slot(input int i, input logic [31:0] pc, input logic [4:0] dst,
                            input logic dv, input logic st, input logic br, input logic [9:0] bhr);
        bus.disp_valid[i] = 1'b1; bus.disp_pc[i] = pc; bus.disp_dst[i] = dst;
        bus.disp_dstvalid[i] = dv; bus.disp_store[i] = st; bus.disp_isbranch[i] = br;
        bus.disp_bhr[i] = bhr;
    endtask

    // n plain ALU ops; destination register is tag mod 32
    task automatic disp_alu(input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            t = (tb_tail + i) % 64;
            set_slot(i, 32'h1000 + 32'(t * 4), 5'(t % 32), 1'b1, 1'b0, 1'b0, 10'h0);
        end
        step();
        tb_tail = (tb_tail + n) % 64;
    endtask

    function automatic exp_t alu_exp(input int tag);
        exp_t e;
        e = '{tag: tag, arfwe: 1'b1, dst: tag % 32, st: 1'b0, br: 1'b0, brcond: 1'b0,
              jmp: 32'h0, pc: 32'h0, bhr: 10'h0};
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                if (bus.com_valid[k]) begin
                    if (sbq.size() == 0) begin
                        chk("spurious_commit", 64'(bus.com_tag[k]), 64'hFFFF);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("com_tag", 64'(bus.com_tag[k]), 64'(e.tag));
                        chk("com_arfwe", 64'(bus.com_arfwe[k]), 64'(e.arfwe));
                        chk("com_dst", 64'(bus.com_dst[k]), 64'(e.dst));
                        if (e.st) chk("com_store", 64'(bus.com_store), 64'h1);
                        if (e.br) begin
                            chk("combr_valid", 64'(bus.combr_valid), 64'h1);
                            chk("combr_brcond", 64'(bus.combr_brcond), 64'(e.brcond));
                            chk("combr_jmpaddr", 64'(bus.combr_jmpaddr), 64'(e.jmp));
                            chk("combr_pc", 64'(bus.combr_pc), 64'(e.pc));
                            chk("combr_bhr", 64'(bus.combr_bhr), 64'(e.bhr));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        do_reset();
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
        chk("rst_com_valid", 64'(bus.com_valid), 64'd0);
        chk("rst_combr_valid", 64'(bus.combr_valid), 64'd0);
        chk("rst_disp_tag1", 64'(bus.disp_tag[1]), 64'd1);

        // two ALU ops retire together
        disp_alu(2);
        chk("t1_count2", 64'(bus.count), 64'd2);
        bus.fin_valid[0] = 1'b1; bus.fin_tag[0] = 6'd0;
        bus.fin_valid[1] = 1'b1; bus.fin_tag[1] = 6'd1;
        sbq.push_back(alu_exp(0)); sbq.push_back(alu_exp(1));
        step();
        chk("t1_com_valid", 64'(bus.com_valid), 64'b11);
        step();
        chk("t1_count0", 64'(bus.count), 64'd0);

        // store ends the commit group
        do_reset();
        set_slot(0, 32'h2000, 5'd0, 1'b0, 1'b1, 1'b0, 10'h0);
        set_slot(1, 32'h2004, 5'd5, 1'b1, 1'b0, 1'b0, 10'h0);
        step();
        bus.fin_valid[0] = 1'b1; bus.fin_tag[0] = 6'd0;
        bus.fin_valid[1] = 1'b1; bus.fin_tag[1] = 6'd1;
        sbq.push_back('{tag: 0, arfwe: 1'b0, dst: 0, st: 1'b1, br: 1'b0, brcond: 1'b0,
                        jmp: 32'h0, pc: 32'h0, bhr: 10'h0});
        sbq.push_back('{tag: 1, arfwe: 1'b1, dst: 5, st: 1'b0, br: 1'b0, brcond: 1'b0,
                        jmp: 32'h0, pc: 32'h0, bhr: 10'h0});
        step();
        chk("t2_store_only", 64'(bus.com_valid), 64'b01);
        chk("t2_com_store", 64'(bus.com_store), 64'd1);
        step();
        chk("t2_alu_next", 64'(bus.com_valid), 64'b01);
        chk("t2_no_store", 64'(bus.com_store), 64'd0);
        step();
        chk("t2_count0", 64'(bus.count), 64'd0);

        // fill to DEPTH, dispatch while full is ignored, then wrap
        do_reset();
        for (int i = 0; i < 32; i++) disp_alu(2);
        chk("t3_full_count", 64'(bus.count), 64'd64);
        chk("t3_full_ready", 64'(bus.disp_ready), 64'd0);
        bus.disp_valid = 2'b11;
        step();
        chk("t3_ignored", 64'(bus.count), 64'd64);
        bus.fin_valid[0] = 1'b1; bus.fin_tag[0] = 6'd0;
        bus.fin_valid[1] = 1'b1; bus.fin_tag[1] = 6'd1;
        sbq.push_back(alu_exp(0)); sbq.push_back(alu_exp(1));
        step();
        step();
        chk("t3_count62", 64'(bus.count), 64'd62);
        chk("t3_ready_again", 64'(bus.disp_ready), 64'd1);
        chk("t3_tail_wrap", 64'(bus.disp_tag[0]), 64'd0);
        disp_alu(1);
        chk("t3_count63", 64'(bus.count), 64'd63);
        chk("t3_not_ready", 64'(bus.disp_ready), 64'd0);

        // move head to 60, then selective flush across the wrap
        do_reset();
        for (int i = 0; i < 30; i++) begin
            disp_alu(2);
            bus.fin_valid[0] = 1'b1; bus.fin_tag[0] = 6'(2 * i);
            bus.fin_valid[1] = 1'b1; bus.fin_tag[1] = 6'(2 * i + 1);
            sbq.push_back(alu_exp(2 * i)); sbq.push_back(alu_exp(2 * i + 1));
            step();
            step();
        end
        chk("t4_head60_empty", 64'(bus.count), 64'd0);
        for (int i = 0; i < 5; i++) disp_alu(2);
        chk("t4_count10", 64'(bus.count), 64'd10);
        bus.flush_valid = 1'b1; bus.flush_tag = 6'd62;
        bus.disp_valid = 2'b11;
        #1;
        chk("t4_flush_no_commit", 64'(bus.com_valid), 64'd0);
        step();
        chk("t4_flush_count", 64'(bus.count), 64'd3);
        chk("t4_flush_tail", 64'(bus.disp_tag[0]), 64'd63);
        tb_tail = 63;
        disp_alu(1);
        chk("t4_count4", 64'(bus.count), 64'd4);
        for (int f = 0; f < 4; f++) begin
            bus.fin_valid[f] = 1'b1; bus.fin_tag[f] = 6'(60 + f);
            sbq.push_back(alu_exp(60 + f));
        end
        step();
        step();
        step();
        chk("t4_drained", 64'(bus.count), 64'd0);

        // branch commit with resolved target
        do_reset();
        set_slot(0, 32'h40, 5'd0, 1'b0, 1'b0, 1'b1, 10'h2A5);
        set_slot(1, 32'h44, 5'd9, 1'b1, 1'b0, 1'b0, 10'h0);
        step();
        tb_tail = 2;
        bus.finbr_valid = 1'b1; bus.finbr_tag = 6'd0; bus.finbr_brcond = 1'b1;
        bus.finbr_jmpaddr = 32'h100;
        bus.fin_valid[0] = 1'b1; bus.fin_tag[0] = 6'd1;
        sbq.push_back('{tag: 0, arfwe: 1'b0, dst: 0, st: 1'b0, br: 1'b1, brcond: 1'b1,
                        jmp: 32'h100, pc: 32'h40, bhr: 10'h2A5});
        sbq.push_back('{tag: 1, arfwe: 1'b1, dst: 9, st: 1'b0, br: 1'b0, brcond: 1'b0,
                        jmp: 32'h0, pc: 32'h0, bhr: 10'h0});
        step();
        chk("t5_branch_alone", 64'(bus.com_valid), 64'b01);
        chk("t5_combr_jmp", 64'(bus.combr_jmpaddr), 64'h100);
        step();
        chk("t5_alu_next", 64'(bus.com_valid), 64'b01);
        chk("t5_no_branch", 64'(bus.combr_valid), 64'd0);
        step();
        chk("t5_count0", 64'(bus.count), 64'd0);

        // asynchronous reset in the middle of a commit
        disp_alu(2);
        bus.fin_valid[0] = 1'b1; bus.fin_tag[0] = 6'd2;
        bus.fin_valid[1] = 1'b1; bus.fin_tag[1] = 6'd3;
        step();
        chk("t6_pre_commit", 64'(bus.com_valid), 64'b11);
        #1 reset = 1'b1;
        #1;
        chk("t6_async_com_valid", 64'(bus.com_valid), 64'd0);
        chk("t6_async_count", 64'(bus.count), 64'd0);
        chk("t6_async_tail", 64'(bus.disp_tag[0]), 64'd0);
        step();
        reset = 1'b0;
        step();
        chk("t6_idle_after", 64'(bus.com_valid), 64'd0);

        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_multiport.md
Name: rob_multiport

Overview:
- Parametrised successor to the two-wide reorder buffer: circular in-order retirement queue with configurable depth, dispatch width, commit width and finish-port count.
- Owns its own head/tail/count, so the separate hidp/freenum wrap logic goes away.
- Adds selective flush of entries younger than a mispredicted branch.
- Sits between dispatch (allocates tags), execution units (mark finish) and ARF/store buffer/branch predictor (commit side).

Parameters:
DEPTH, 64, entry count; power of two, >= 4
TAG_W, $clog2(DEPTH), tag width
DISP_W, 2, dispatch slots per cycle (1..4)
COMMIT_W, 2, commit slots per cycle (1..4)
NUM_FIN, 5, generic finish ports
PC_W, 32, PC and jump-address width
REG_W, 5, architectural register index width
BHR_W, 10, branch history width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
disp_valid  in  DISP_W  per-slot dispatch request; valid bits must be contiguous from slot 0
disp_ready  out  1  all DISP_W slots can be accepted (free >= DISP_W)
disp_tag  out  DISP_W*TAG_W  tags for this cycle's slots (tail+i)
disp_pc  in  DISP_W*PC_W  instruction PCs
disp_isbranch / disp_store / disp_dstvalid  in  DISP_W each  entry attributes
disp_dst  in  DISP_W*REG_W  destination registers
disp_bhr  in  DISP_W*BHR_W  branch history
fin_valid  in  NUM_FIN  finish strobes
fin_tag  in  NUM_FIN*TAG_W  finishing tags
finbr_valid  in  1  branch-unit finish
finbr_tag  in  TAG_W  branch tag
finbr_brcond  in  1  resolved direction
finbr_jmpaddr  in  PC_W  resolved target
flush_valid  in  1  mispredict flush
flush_tag  in  TAG_W  mispredicted branch tag (kept; younger entries squashed)
com_valid  out  COMMIT_W  per-slot commit, contiguous from slot 0
com_tag  out  COMMIT_W*TAG_W  committed tags
com_arfwe  out  COMMIT_W  com_valid & dstvalid
com_dst  out  COMMIT_W*REG_W  destination registers
com_store  out  1  a store commits this cycle
combr_valid  out  1  a branch commits this cycle
combr_pc / combr_bhr / combr_brcond / combr_jmpaddr  out  PC_W / BHR_W / 1 / PC_W  committing branch info
count  out  TAG_W+1  occupied entries

Behaviour:
- Reset: head=tail=count=0, finish/brcond cleared; all com_*/combr_* outputs 0; disp_ready=1. Payload arrays not reset.
- Dispatch: when disp_ready, each valid slot i writes entry tail+i (mod DEPTH), clears its finish bit; tail += popcount(disp_valid). disp_valid while !disp_ready is ignored. disp_tag is combinational from tail.
- Finish: any fin/finbr strobe sets finish[tag] next cycle; finbr also writes brcond/jmpaddr. Same-cycle dispatch clear and finish on the same tag: finish wins (cannot occur legally; assertion).
- Commit (combinational outputs, pointer update at clk): slot k valid iff slot k-1 valid, k < count, finish[head+k], and no earlier slot committed a branch or store. A branch or store may commit only as the last valid slot → at most one branch and one store per cycle. head += committed count.
- Flush: in the flush_valid cycle no commit (all com_* 0) and dispatch is ignored; next cycle tail = flush_tag+1, count = distance(head, flush_tag)+1. Flush has priority over dispatch; finish strobes are still recorded.
- count = count + dispatched - committed; full when count==DEPTH; wrap via TAG_W-bit modular pointers.
- Reset asserted mid-operation clears state immediately (async).

Optional Feature:
- ROB_EXC_EN: adds fin_exc (NUM_FIN) input, exc_commit output (1) and exc_pc output (PC_W). With it: a finish strobe with exc set marks the entry; that entry commits alone in slot 0 with com_arfwe=0, asserts exc_commit/exc_pc, and the buffer then auto-flushes everything behind it (head=tail, count=0).
- Without it: no exc ports or exception state.

Decomposition:
- Shared package rob_pkg: tag typedef, entry payload struct (pc, dst, dstvalid, store, isbranch, bhr), DEPTH/TAG_W defaults.
- One sub-module rob_commit_sel: combinational COMMIT_W-slot selection from head, count, finish/isbranch/store vectors.

Test Plan:
- Reset then dispatch 2 ALU ops (tags 0,1), finish both → next cycle com_valid=2'b11, com_tag 0,1, count 0.
- Dispatch store at 0, ALU at 1, both finished → cycle1 commits tag0 only with com_store=1; tag1 the next cycle.
- Fill DEPTH=64 → disp_ready=0, count=64; finish and commit 2 → disp_ready=1 and tail wraps to 0.
- 10 entries at head=60; flush_tag=62 → count=3, tail=63; later dispatch gets tag 63.
- Branch at head, finbr_brcond=1, jmpaddr=0x100 → combr_valid=1, combr_jmpaddr=0x100, slot1 not committed.
- Async reset asserted mid-commit → com_valid=0 immediately, count=0.
